// File: rtl/fetch_sequencer.sv
// Sequences the BRAM fetch unit for LOAD/STORE commands from the decoder.
// Optional one-entry command buffer enabled by defining FETCH_SEQ_CMDQ_EN.
module fetch_sequencer #(
    parameter int BRAM_LAT    = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_OP,
    input  logic [1:0] CMD_DIMEN,
    input  logic [3:0] CMD_ADDR,
    input  logic [1:0] CMD_PE_SEL,
    input  logic       CMD_SEL_2x2,
    input  logic       CMD_SEL_4,
    output logic [1:0] DIMEN,
    output logic [3:0] ADDRESS,
    output logic [1:0] PE_SEL,
    output logic       PE_SEL_2x2,
    output logic       PE_SEL_4,
    output logic       ADDR_RST,
    output logic       ADDR_START,
    output logic       WRADDR_START,
    input  logic       FETCH_DONE,
    input  logic       STORE_DONE,
    output logic       PE_WR_EN,
    output logic       OP_DONE,
    output logic       ERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_STORE, S_DONE} state_t;

    localparam int CW         = ($clog2(TIMEOUT_CYC + 1) < 3) ? 3 : $clog2(TIMEOUT_CYC + 1);
    localparam int DRAIN_LAST = (BRAM_LAT > 1) ? BRAM_LAT - 2 : 0;

    state_t          state, next;
    logic [CW-1:0]   cnt;
    logic [BRAM_LAT-1:0] pe_sr;
    logic            err_q;
    logic            op_q;
    logic [1:0]      dimen_q, pe_sel_q;
    logic [3:0]      addr_q;
    logic            sel2_q, sel4_q;
    logic            accept, start_in, start;
    logic            wd_hit, store_last;

    assign accept     = CMD_VALID && CMD_READY;
    assign wd_hit     = (cnt == CW'(TIMEOUT_CYC));
    assign store_last = (state == S_STORE) && (cnt == CW'(3));

`ifdef FETCH_SEQ_CMDQ_EN
    logic       buf_vld, buf_op, buf_s2, buf_s4;
    logic [1:0] buf_dimen, buf_pe_sel;
    logic [3:0] buf_addr;
    logic       idle_or_done, start_buf, push;

    assign CMD_READY    = !buf_vld;
    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign start_buf    = buf_vld && idle_or_done;
    assign start_in     = accept && idle_or_done;
    assign push         = accept && !idle_or_done;
    assign start        = start_in || start_buf;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            buf_vld    <= 1'b0;
            buf_op     <= 1'b0;
            buf_dimen  <= '0;
            buf_addr   <= '0;
            buf_pe_sel <= '0;
            buf_s2     <= 1'b0;
            buf_s4     <= 1'b0;
        end else if (push) begin
            buf_vld    <= 1'b1;
            buf_op     <= CMD_OP;
            buf_dimen  <= CMD_DIMEN;
            buf_addr   <= CMD_ADDR;
            buf_pe_sel <= CMD_PE_SEL;
            buf_s2     <= CMD_SEL_2x2;
            buf_s4     <= CMD_SEL_4;
        end else if (start_buf) begin
            buf_vld <= 1'b0;
        end
    end
`else
    assign CMD_READY = (state == S_IDLE);
    assign start_in  = accept;
    assign start     = start_in;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            op_q     <= 1'b0;
            dimen_q  <= '0;
            addr_q   <= '0;
            pe_sel_q <= '0;
            sel2_q   <= 1'b0;
            sel4_q   <= 1'b0;
        end else if (start_in) begin
            op_q     <= CMD_OP;
            dimen_q  <= CMD_DIMEN;
            addr_q   <= CMD_ADDR;
            pe_sel_q <= CMD_PE_SEL;
            sel2_q   <= CMD_SEL_2x2;
            sel4_q   <= CMD_SEL_4;
`ifdef FETCH_SEQ_CMDQ_EN
        end else if (start_buf) begin
            op_q     <= buf_op;
            dimen_q  <= buf_dimen;
            addr_q   <= buf_addr;
            pe_sel_q <= buf_pe_sel;
            sel2_q   <= buf_s2;
            sel4_q   <= buf_s4;
`endif
        end
    end

    assign DIMEN      = dimen_q;
    assign ADDRESS    = addr_q;
    assign PE_SEL     = pe_sel_q;
    assign PE_SEL_2x2 = sel2_q;
    assign PE_SEL_4   = sel4_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= next;
            if (next != state)
                cnt <= '0;
            else if (state == S_LOAD || state == S_STORE || state == S_DRAIN)
                cnt <= cnt + CW'(1);
            if (start)
                err_q <= 1'b0;
            else if ((state == S_LOAD || state == S_STORE) && wd_hit)
                err_q <= 1'b1;
            else if (store_last && !STORE_DONE)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        next         = state;
        ADDR_RST     = 1'b0;
        ADDR_START   = 1'b0;
        WRADDR_START = 1'b0;
        OP_DONE      = 1'b0;
        ERR          = 1'b0;
        case (state)
            S_IDLE:  if (start) next = S_CLR;
            S_CLR: begin
                ADDR_RST = 1'b1;
                next     = op_q ? S_STORE : S_LOAD;
            end
            S_LOAD: begin
                // The FETCH_DONE cycle itself is the first drain cycle, so DRAIN covers BRAM_LAT-1.
                if (wd_hit) begin
                    next = S_DONE;
                end else begin
                    ADDR_START = !FETCH_DONE;
                    if (FETCH_DONE) next = (BRAM_LAT > 1) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: if (cnt == CW'(DRAIN_LAST)) next = S_DONE;
            S_STORE: begin
                if (wd_hit) begin
                    next = S_DONE;
                end else begin
                    ADDR_START   = 1'b1;
                    WRADDR_START = 1'b1;
                    if (store_last) next = S_DONE;
                end
            end
            S_DONE: begin
                OP_DONE = 1'b1;
                ERR     = err_q;
                next    = start ? S_CLR : S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pe_sr <= '0;
        end else begin
            pe_sr[0] <= ADDR_START && !WRADDR_START;
            for (int unsigned i = 1; i < BRAM_LAT; i++)
                pe_sr[i] <= pe_sr[i-1];
        end
    end

    assign PE_WR_EN = pe_sr[BRAM_LAT-1] && !WRADDR_START;
    assign BUSY     = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural fetch-unit model.
module tb_fetch_sequencer;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       CMD_VALID, CMD_READY, CMD_OP, CMD_SEL_2x2, CMD_SEL_4;
    logic [1:0] CMD_DIMEN, CMD_PE_SEL, DIMEN, PE_SEL;
    logic [3:0] CMD_ADDR, ADDRESS;
    logic       PE_SEL_2x2, PE_SEL_4, ADDR_RST, ADDR_START, WRADDR_START;
    logic       FETCH_DONE, STORE_DONE, PE_WR_EN, OP_DONE, ERR, BUSY;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.BRAM_LAT(1), .TIMEOUT_CYC(64)) dut (
        .CLK(CLK), .RSTN(RSTN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DIMEN(CMD_DIMEN), .CMD_ADDR(CMD_ADDR),
        .CMD_PE_SEL(CMD_PE_SEL), .CMD_SEL_2x2(CMD_SEL_2x2), .CMD_SEL_4(CMD_SEL_4),
        .DIMEN(DIMEN), .ADDRESS(ADDRESS), .PE_SEL(PE_SEL), .PE_SEL_2x2(PE_SEL_2x2),
        .PE_SEL_4(PE_SEL_4), .ADDR_RST(ADDR_RST), .ADDR_START(ADDR_START),
        .WRADDR_START(WRADDR_START), .FETCH_DONE(FETCH_DONE), .STORE_DONE(STORE_DONE),
        .PE_WR_EN(PE_WR_EN), .OP_DONE(OP_DONE), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Fetch-unit model: beat counter cleared by ADDR_RST, advanced by ADDR_START.
    logic [7:0] fcnt;
    logic       fetch_stuck = 1'b0;
    logic       store_ok    = 1'b1;
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN)          fcnt <= 8'd0;
        else if (ADDR_RST)  fcnt <= 8'd0;
        else if (ADDR_START) fcnt <= fcnt + 8'd1;
    end
    assign FETCH_DONE = !fetch_stuck && (fcnt == (8'd2 << DIMEN));
    assign STORE_DONE = store_ok && (fcnt == 8'd3);

    logic [127:0] tr_rst, tr_start, tr_wr, tr_pe, tr_done, tr_err;

    function automatic void stats(input logic [127:0] v, input int n,
                                  output int f, output int l, output int c);
        f = -1; l = -1; c = 0;
        for (int i = 0; i < n; i++)
            if (v[i]) begin
                if (f < 0) f = i;
                l = i;
                c++;
            end
    endfunction

    task automatic sample(input int k);
        tr_rst[k]   = ADDR_RST;
        tr_start[k] = ADDR_START;
        tr_wr[k]    = WRADDR_START;
        tr_pe[k]    = PE_WR_EN;
        tr_done[k]  = OP_DONE;
        tr_err[k]   = ERR;
    endtask

    // Called just after a negedge; cycle 0 is the accept cycle.
    task automatic run_cmd(input logic op, input logic [1:0] dim, input logic [3:0] addr,
                           input logic [1:0] psel, input logic s2, input logic s4, input int ncyc);
        tr_rst = '0; tr_start = '0; tr_wr = '0; tr_pe = '0; tr_done = '0; tr_err = '0;
        CMD_OP = op; CMD_DIMEN = dim; CMD_ADDR = addr;
        CMD_PE_SEL = psel; CMD_SEL_2x2 = s2; CMD_SEL_4 = s4;
        CMD_VALID = 1'b1;
        #1 sample(0);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        for (int k = 1; k < ncyc; k++) begin
            @(negedge CLK);
            sample(k);
        end
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", CMD_READY); end
        total++; if ({ADDR_RST, ADDR_START, WRADDR_START, PE_WR_EN, OP_DONE, ERR, BUSY} !== 7'b0) begin
            bad++; $display("FAIL rst_strobes got=%b exp=0", {ADDR_RST, ADDR_START, WRADDR_START, PE_WR_EN, OP_DONE, ERR, BUSY}); end
        total++; if ({DIMEN, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4} !== 10'b0) begin
            bad++; $display("FAIL rst_fields got=%h exp=0", {DIMEN, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4}); end
        RSTN = 1'b1;
        @(negedge CLK);
        total++; if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_idle busy=%b ready=%b exp busy=0 ready=1", BUSY, CMD_READY); end
    endtask

    task automatic test_load_dimen1;
        int f, l, c;
        run_cmd(1'b0, 2'd1, 4'd4, 2'd2, 1'b1, 1'b0, 12);
        stats(tr_rst, 12, f, l, c);
        total++; if (f != 1 || c != 1) begin bad++; $display("FAIL l1_addr_rst first=%0d cnt=%0d exp first=1 cnt=1", f, c); end
        stats(tr_start, 12, f, l, c);
        total++; if (f != 2 || l != 5 || c != 4) begin bad++; $display("FAIL l1_addr_start %0d..%0d cnt=%0d exp 2..5 cnt=4", f, l, c); end
        stats(tr_pe, 12, f, l, c);
        total++; if (f != 3 || l != 6 || c != 4) begin bad++; $display("FAIL l1_pe_wr %0d..%0d cnt=%0d exp 3..6 cnt=4", f, l, c); end
        stats(tr_done, 12, f, l, c);
        total++; if (f != 7 || c != 1) begin bad++; $display("FAIL l1_op_done first=%0d cnt=%0d exp first=7 cnt=1", f, c); end
        stats(tr_err, 12, f, l, c);
        total++; if (c != 0) begin bad++; $display("FAIL l1_err cnt=%0d exp=0", c); end
        total++; if (ADDRESS !== 4'd4 || DIMEN !== 2'd1) begin bad++; $display("FAIL l1_fields addr=%0d dimen=%0d exp addr=4 dimen=1", ADDRESS, DIMEN); end
        total++; if ({PE_SEL, PE_SEL_2x2, PE_SEL_4} !== 4'b1010) begin bad++; $display("FAIL l1_pesel got=%b exp=1010", {PE_SEL, PE_SEL_2x2, PE_SEL_4}); end
    endtask

    task automatic test_load_dimen_bounds;
        int f, l, c;
        run_cmd(1'b0, 2'd3, 4'd9, 2'd0, 1'b0, 1'b1, 24);
        stats(tr_start, 24, f, l, c);
        total++; if (f != 2 || l != 17 || c != 16) begin bad++; $display("FAIL l3_addr_start %0d..%0d cnt=%0d exp 2..17 cnt=16", f, l, c); end
        stats(tr_pe, 24, f, l, c);
        total++; if (f != 3 || c != 16) begin bad++; $display("FAIL l3_pe_wr first=%0d cnt=%0d exp first=3 cnt=16", f, c); end
        stats(tr_done, 24, f, l, c);
        total++; if (f != 19 || c != 1) begin bad++; $display("FAIL l3_op_done first=%0d cnt=%0d exp first=19 cnt=1", f, c); end
        run_cmd(1'b0, 2'd0, 4'd1, 2'd1, 1'b0, 1'b0, 8);
        stats(tr_start, 8, f, l, c);
        total++; if (f != 2 || l != 3 || c != 2) begin bad++; $display("FAIL l0_addr_start %0d..%0d cnt=%0d exp 2..3 cnt=2", f, l, c); end
        stats(tr_done, 8, f, l, c);
        total++; if (f != 5 || c != 1) begin bad++; $display("FAIL l0_op_done first=%0d cnt=%0d exp first=5 cnt=1", f, c); end
        total++; if (ADDRESS !== 4'd1) begin bad++; $display("FAIL l0_addr got=%0d exp=1", ADDRESS); end
    endtask

    task automatic test_store;
        int f, l, c;
        store_ok = 1'b1;
        run_cmd(1'b1, 2'd2, 4'd7, 2'd3, 1'b0, 1'b0, 9);
        stats(tr_wr, 9, f, l, c);
        total++; if (f != 2 || l != 5 || c != 4) begin bad++; $display("FAIL st_wraddr %0d..%0d cnt=%0d exp 2..5 cnt=4", f, l, c); end
        stats(tr_start, 9, f, l, c);
        total++; if (f != 2 || c != 4) begin bad++; $display("FAIL st_addr_start first=%0d cnt=%0d exp first=2 cnt=4", f, c); end
        stats(tr_pe, 9, f, l, c);
        total++; if (c != 0) begin bad++; $display("FAIL st_pe_wr cnt=%0d exp=0", c); end
        stats(tr_done, 9, f, l, c);
        total++; if (f != 6 || c != 1) begin bad++; $display("FAIL st_op_done first=%0d cnt=%0d exp first=6 cnt=1", f, c); end
        stats(tr_err, 9, f, l, c);
        total++; if (c != 0) begin bad++; $display("FAIL st_err cnt=%0d exp=0", c); end
        store_ok = 1'b0;
        run_cmd(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, 1'b0, 9);
        stats(tr_err, 9, f, l, c);
        total++; if (f != 6 || c != 1) begin bad++; $display("FAIL st_bad_err first=%0d cnt=%0d exp first=6 cnt=1", f, c); end
        stats(tr_done, 9, f, l, c);
        total++; if (f != 6) begin bad++; $display("FAIL st_bad_op_done first=%0d exp=6", f); end
        store_ok = 1'b1;
    endtask

    task automatic test_timeout;
        int f, l, c;
        fetch_stuck = 1'b1;
        run_cmd(1'b0, 2'd0, 4'd3, 2'd0, 1'b0, 1'b0, 72);
        stats(tr_start, 72, f, l, c);
        total++; if (f != 2 || l != 65 || c != 64) begin bad++; $display("FAIL wd_addr_start %0d..%0d cnt=%0d exp 2..65 cnt=64", f, l, c); end
        stats(tr_done, 72, f, l, c);
        total++; if (f != 67 || c != 1) begin bad++; $display("FAIL wd_op_done first=%0d cnt=%0d exp first=67 cnt=1", f, c); end
        stats(tr_err, 72, f, l, c);
        total++; if (f != 67 || c != 1) begin bad++; $display("FAIL wd_err first=%0d cnt=%0d exp first=67 cnt=1", f, c); end
        fetch_stuck = 1'b0;
        run_cmd(1'b0, 2'd0, 4'd5, 2'd0, 1'b0, 1'b0, 8);
        stats(tr_done, 8, f, l, c);
        total++; if (f != 5 || c != 1) begin bad++; $display("FAIL wd_next_op_done first=%0d cnt=%0d exp first=5 cnt=1", f, c); end
        stats(tr_err, 8, f, l, c);
        total++; if (c != 0) begin bad++; $display("FAIL wd_next_err cnt=%0d exp=0", c); end
    endtask

    task automatic test_back_to_back;
        int f, l, c, acc;
        int acc_cyc [2];
`ifdef FETCH_SEQ_CMDQ_EN
        int exp_acc2 = 1, exp_rst2 = 6, exp_done2 = 10;
`else
        int exp_acc2 = 6, exp_rst2 = 7, exp_done2 = 11;
`endif
        tr_rst = '0; tr_done = '0;
        acc = 0; acc_cyc[0] = -1; acc_cyc[1] = -1;
        CMD_OP = 1'b0; CMD_DIMEN = 2'd0; CMD_ADDR = 4'd8; CMD_PE_SEL = 2'd0;
        CMD_SEL_2x2 = 1'b0; CMD_SEL_4 = 1'b0; CMD_VALID = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            sample(k);
            if (CMD_VALID && CMD_READY && acc < 2) begin acc_cyc[acc] = k; acc++; end
            @(posedge CLK);
            #1 if (acc >= 2) CMD_VALID = 1'b0;
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        total++; if (acc_cyc[0] != 0 || acc_cyc[1] != exp_acc2) begin
            bad++; $display("FAIL b2b_accepts got=%0d,%0d exp=0,%0d", acc_cyc[0], acc_cyc[1], exp_acc2); end
        stats(tr_rst, 20, f, l, c);
        total++; if (f != 1 || l != exp_rst2 || c != 2) begin bad++; $display("FAIL b2b_clr %0d..%0d cnt=%0d exp 1..%0d cnt=2", f, l, c, exp_rst2); end
        stats(tr_done, 20, f, l, c);
        total++; if (f != 5 || l != exp_done2 || c != 2) begin bad++; $display("FAIL b2b_op_done %0d..%0d cnt=%0d exp 5..%0d cnt=2", f, l, c, exp_done2); end
    endtask

    task automatic test_reset_mid_load;
        int seen_done;
        CMD_OP = 1'b0; CMD_DIMEN = 2'd2; CMD_ADDR = 4'd6; CMD_PE_SEL = 2'd1;
        CMD_SEL_2x2 = 1'b1; CMD_SEL_4 = 1'b1; CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (ADDR_START !== 1'b1) begin bad++; $display("FAIL mid_beat2 addr_start=%b exp=1", ADDR_START); end
        RSTN = 1'b0;
        #1;
        total++; if ({ADDR_RST, ADDR_START, WRADDR_START, PE_WR_EN, OP_DONE, ERR, BUSY} !== 7'b0) begin
            bad++; $display("FAIL mid_rst_strobes got=%b exp=0", {ADDR_RST, ADDR_START, WRADDR_START, PE_WR_EN, OP_DONE, ERR, BUSY}); end
        total++; if (CMD_READY !== 1'b1 || ADDRESS !== 4'd0) begin bad++; $display("FAIL mid_rst_ready ready=%b addr=%0d exp ready=1 addr=0", CMD_READY, ADDRESS); end
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (OP_DONE) seen_done++;
            if (k == 1) RSTN = 1'b1;
        end
        repeat (3) begin @(negedge CLK); if (OP_DONE) seen_done++; end
        total++; if (seen_done != 0) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=0", seen_done); end
        total++; if (BUSY !== 1'b0 || CMD_READY !== 1'b1) begin bad++; $display("FAIL mid_rst_idle busy=%b ready=%b exp busy=0 ready=1", BUSY, CMD_READY); end
    endtask

    initial begin
        RSTN = 1'b0; CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_DIMEN = 2'd0; CMD_ADDR = 4'd0;
        CMD_PE_SEL = 2'd0; CMD_SEL_2x2 = 1'b0; CMD_SEL_4 = 1'b0;
        test_reset;
        test_load_dimen1;
        test_load_dimen_bounds;
        test_store;
        test_timeout;
        test_back_to_back;
        test_reset_mid_load;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
